// File: rtl/sdio_req_arb_pkg.sv
// Shared types for the SDIO request arbiter: descriptor layout, FSM states,
// txrx status-bit positions and a one-hot helper.
package sdio_pkg;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] arg;
    logic [2:0]  rsp_type;
    logic        data_en;
    logic        rwn;
    logic        quad;
    logic [9:0]  block_size;
    logic [7:0]  block_num;
  } sdio_req_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2,
    ST_DONE   = 2'd3
  } sdio_state_e;

  localparam int unsigned STAT_W                = 16;
  localparam int unsigned STAT_CMD_CRC_ERR_BIT  = 0;
  localparam int unsigned STAT_CMD_TMO_BIT      = 1;
  localparam int unsigned STAT_DATA_CRC_ERR_BIT = 8;
  localparam int unsigned STAT_DATA_TMO_BIT     = 9;

  function automatic logic [1:0] idx2oh(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sdio_req_arb_if.sv
// Requester-side bundle of the SDIO arbiter: descriptor handshake plus
// completion reporting. master = requesters, slave = arbiter.
interface sdio_req_arb_if;
  import sdio_pkg::*;

  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  sdio_req_t [1:0]       req_desc;
  logic [1:0]            done;
  logic [STAT_W-1:0]     done_status;
  logic                  done_tmo;

  modport master (
    output req_valid, req_desc,
    input  req_ready, done, done_status, done_tmo
  );

  modport slave (
    input  req_valid, req_desc,
    output req_ready, done, done_status, done_tmo
  );
endinterface

// File: rtl/sdio_rr_arb2.sv
// Two-way round-robin grant; the last-granted pointer only moves when the
// grant is actually accepted. Pointer resets to 1 so requester 0 wins first.
module sdio_rr_arb2 (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  output logic [1:0] grant_o,
  output logic       grant_idx_o
);
  import sdio_pkg::*;

  logic last_q, last_d;

  always_comb begin
    grant_idx_o = (valid_i == 2'b11) ? ~last_q : valid_i[1];
    grant_o     = (valid_i == 2'b00) ? 2'b00 : idx2oh(grant_idx_o);
    last_d      = accept_i ? grant_idx_o : last_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) last_q <= 1'b1;
    else         last_q <= last_d;
  end
endmodule

// File: rtl/sdio_req_arb.sv
// Arbitrates two SDIO descriptor sources onto one txrx core and reports completion.
// Optional busy timeout is built when SDIO_ARB_TIMEOUT_EN is defined.
module sdio_req_arb
  import sdio_pkg::*;
#(
  parameter int TMO_W = 24
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  sdio_req_arb_if.slave     req_if,
  output logic              cmd_start_o,
  output logic [5:0]        cmd_op_o,
  output logic [31:0]       cmd_arg_o,
  output logic [2:0]        cmd_rsp_type_o,
  output logic              data_en_o,
  output logic              data_rwn_o,
  output logic              data_quad_o,
  output logic [9:0]        data_block_size_o,
  output logic [7:0]        data_block_num_o,
  output logic              clr_stat_o,
  input  logic              eot_i,
  input  logic [STAT_W-1:0] status_i,
  input  logic [TMO_W-1:0]  tmo_cycles_i,
  output logic              busy_o
);

  sdio_state_e       state_q, state_d;
  sdio_req_t         desc_q, desc_d;
  logic              gidx_q, gidx_d;
  logic              cmd_start_q, cmd_start_d;
  logic [1:0]        done_q, done_d;
  logic              clr_q, clr_d;
  logic              busy_q, busy_d;
  logic [STAT_W-1:0] status_q, status_d;
  logic              tmo_q, tmo_d;
  logic              tmo_hit;

  logic [1:0] grant;
  logic       grant_idx;
  logic       accept;

  // Ready is gated by reset so nothing is accepted while rstn_i is low.
  assign accept = rstn_i && (state_q == ST_IDLE) && (req_if.req_valid != 2'b00);

  sdio_rr_arb2 u_arb (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .valid_i     (req_if.req_valid),
    .accept_i    (accept),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

`ifdef SDIO_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] cnt_q, cnt_d;

  // cnt_d is the number of BUSY cycles including the current one.
  always_comb begin
    cnt_d   = cnt_q;
    tmo_hit = 1'b0;
    if (state_q == ST_LAUNCH) begin
      cnt_d = '0;
    end else if (state_q == ST_BUSY) begin
      cnt_d   = cnt_q + 1'b1;
      tmo_hit = (tmo_cycles_i != '0) && (cnt_d == tmo_cycles_i);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^tmo_cycles_i;
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    desc_d   = desc_q;
    gidx_d   = gidx_q;
    status_d = status_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          desc_d  = req_if.req_desc[grant_idx];
          gidx_d  = grant_idx;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_BUSY;
      ST_BUSY: begin
        // eot takes priority over a timeout expiring in the same cycle.
        if (eot_i) begin
          status_d = status_i;
          tmo_d    = 1'b0;
          state_d  = ST_DONE;
        end else if (tmo_hit) begin
          status_d = status_i;
          tmo_d    = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Pulses are registered from the next state so they align with it.
    cmd_start_d = (state_d == ST_LAUNCH);
    clr_d       = (state_d == ST_DONE);
    done_d      = (state_d == ST_DONE) ? idx2oh(gidx_d) : 2'b00;
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      desc_q      <= '0;
      gidx_q      <= 1'b0;
      cmd_start_q <= 1'b0;
      done_q      <= 2'b00;
      clr_q       <= 1'b0;
      busy_q      <= 1'b0;
      status_q    <= '0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      desc_q      <= desc_d;
      gidx_q      <= gidx_d;
      cmd_start_q <= cmd_start_d;
      done_q      <= done_d;
      clr_q       <= clr_d;
      busy_q      <= busy_d;
      status_q    <= status_d;
      tmo_q       <= tmo_d;
    end
  end

  assign req_if.req_ready   = accept ? grant : 2'b00;
  assign req_if.done        = done_q;
  assign req_if.done_status = status_q;
  assign req_if.done_tmo    = tmo_q;

  assign cmd_start_o       = cmd_start_q;
  assign cmd_op_o          = desc_q.op;
  assign cmd_arg_o         = desc_q.arg;
  assign cmd_rsp_type_o    = desc_q.rsp_type;
  assign data_en_o         = desc_q.data_en;
  assign data_rwn_o        = desc_q.rwn;
  assign data_quad_o       = desc_q.quad;
  assign data_block_size_o = desc_q.block_size;
  assign data_block_num_o  = desc_q.block_num;
  assign clr_stat_o        = clr_q;
  assign busy_o            = busy_q;

endmodule

// File: tb/tb_sdio_req_arb.sv
// Bench for sdio_req_arb: randomized transactions checked against a
// transaction-level model of grant order, cycle timing and status capture.
module tb_sdio_req_arb;
  import sdio_pkg::*;

  logic        clk;
  logic        rstn;
  logic        cmd_start;
  logic [5:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic [2:0]  cmd_rsp_type;
  logic        data_en, data_rwn, data_quad;
  logic [9:0]  data_block_size;
  logic [7:0]  data_block_num;
  logic        clr_stat;
  logic        eot;
  logic [15:0] status;
  logic [23:0] tmo_cycles;
  logic        busy;

  sdio_req_arb_if vif ();

  sdio_req_arb #(.TMO_W(24)) dut (
    .clk_i             (clk),
    .rstn_i            (rstn),
    .req_if            (vif),
    .cmd_start_o       (cmd_start),
    .cmd_op_o          (cmd_op),
    .cmd_arg_o         (cmd_arg),
    .cmd_rsp_type_o    (cmd_rsp_type),
    .data_en_o         (data_en),
    .data_rwn_o        (data_rwn),
    .data_quad_o       (data_quad),
    .data_block_size_o (data_block_size),
    .data_block_num_o  (data_block_num),
    .clr_stat_o        (clr_stat),
    .eot_i             (eot),
    .status_i          (status),
    .tmo_cycles_i      (tmo_cycles),
    .busy_o            (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_cmp = 0;
  int          n_err = 0;
  sdio_req_t   d [2];
  int          last_m = 1;      // model: last granted requester
  logic [15:0] st_m   = '0;     // model: last reported status
  logic        tmo_m  = 1'b0;   // model: last reported timeout flag

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic sdio_req_t rnd_desc();
    sdio_req_t r;
    r.op         = 6'($urandom);
    r.arg        = $urandom;
    r.rsp_type   = 3'($urandom);
    r.data_en    = 1'($urandom);
    r.rwn        = 1'($urandom);
    r.quad       = 1'($urandom);
    r.block_size = 10'($urandom);
    r.block_num  = 8'($urandom);
    return r;
  endfunction

  function automatic logic [61:0] dut_desc();
    return {cmd_op, cmd_arg, cmd_rsp_type, data_en, data_rwn, data_quad,
            data_block_size, data_block_num};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 64'(vif.req_ready), 64'(0));
    chk({tag, "_done"}, 64'(vif.done), 64'(0));
    chk({tag, "_start"}, 64'(cmd_start), 64'(0));
    chk({tag, "_clr"}, 64'(clr_stat), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_desc"}, 64'(dut_desc()), 64'(0));
    chk({tag, "_status"}, 64'(vif.done_status), 64'(0));
    chk({tag, "_tmo"}, 64'(vif.done_tmo), 64'(0));
  endtask

  // One transaction, entered and left at the falling edge of an IDLE cycle.
  task automatic txn(input logic [1:0] v, input int eot_at, input logic [15:0] st, input int tmo);
    int          w;
    int          end_k;
    logic        exp_tmo;
    logic [15:0] exp_st;
    sdio_req_t   wd;
    w       = (v == 2'b11) ? 1 - last_m : (v[1] ? 1 : 0);
    end_k   = eot_at;
    exp_tmo = 1'b0;
`ifdef SDIO_ARB_TIMEOUT_EN
    if (tmo != 0 && (eot_at == 0 || tmo < eot_at)) begin
      end_k   = tmo;
      exp_tmo = 1'b1;
    end
`endif
    if (end_k <= 0) begin
      $display("FAIL txn_setup: observed end %0d expected >0", end_k);
      $fatal(1, "unterminated transaction");
    end
    exp_st        = st;
    tmo_cycles    = 24'(tmo);
    vif.req_valid = v;
    vif.req_desc  = {d[1], d[0]};
    eot           = 1'b0;
    #1;
    chk("accept_ready", 64'(vif.req_ready), 64'(idx2oh(1'(w))));
    chk("accept_busy", 64'(busy), 64'(0));
    wd   = d[w];
    d[w] = rnd_desc();
    @(negedge clk);
    // launch cycle: stray eot here must be ignored
    vif.req_desc = {d[1], d[0]};
    eot          = 1'b1;
    status       = 16'($urandom);
    #1;
    chk("launch_start", 64'(cmd_start), 64'(1));
    chk("launch_ready", 64'(vif.req_ready), 64'(0));
    chk("launch_busy", 64'(busy), 64'(1));
    chk("launch_desc", 64'(dut_desc()), 64'(wd));
    for (int k = 1; k <= end_k; k++) begin
      @(negedge clk);
      eot    = (k == eot_at);
      status = (k == eot_at) ? st : 16'($urandom);
      if (k == end_k && exp_tmo) exp_st = status;
      #1;
      chk("busy_start", 64'(cmd_start), 64'(0));
      chk("busy_ready", 64'(vif.req_ready), 64'(0));
      chk("busy_done", 64'(vif.done), 64'(0));
      chk("busy_desc", 64'(dut_desc()), 64'(wd));
      chk("busy_st_hold", 64'(vif.done_status), 64'(st_m));
      chk("busy_tmo_hold", 64'(vif.done_tmo), 64'(tmo_m));
    end
    @(negedge clk);
    eot    = 1'b0;
    status = 16'($urandom);
    #1;
    chk("done_pulse", 64'(vif.done), 64'(idx2oh(1'(w))));
    chk("done_clr", 64'(clr_stat), 64'(1));
    chk("done_status", 64'(vif.done_status), 64'(exp_st));
    chk("done_tmo", 64'(vif.done_tmo), 64'(exp_tmo));
    chk("done_ready", 64'(vif.req_ready), 64'(0));
    st_m   = exp_st;
    tmo_m  = exp_tmo;
    last_m = w;
    @(negedge clk);
    #1;
    chk("idle_done", 64'(vif.done), 64'(0));
    chk("idle_clr", 64'(clr_stat), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_st_hold", 64'(vif.done_status), 64'(st_m));
    chk("idle_desc", 64'(dut_desc()), 64'(wd));
    $display("txn req%0d eot_at=%0d tmo=%0d -> status=%h tmo_flag=%0b", w, eot_at, tmo, exp_st, exp_tmo);
  endtask

  initial begin
    int w_pre;
    rstn          = 1'b0;
    eot           = 1'b0;
    status        = '0;
    tmo_cycles    = '0;
    d[0]          = rnd_desc();
    d[1]          = rnd_desc();
    vif.req_valid = 2'b11;
    vif.req_desc  = {d[1], d[0]};
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rstn          = 1'b1;
    vif.req_valid = 2'b00;
    // eot while idle must not produce a completion
    @(negedge clk);
    eot = 1'b1;
    @(negedge clk);
    eot = 1'b0;
    #1;
    chk("idle_eot_done", 64'(vif.done), 64'(0));
    chk("idle_eot_busy", 64'(busy), 64'(0));

    d[0].op        = 6'd17;
    d[0].arg       = 32'h200;
    d[0].block_num = 8'd0;
    txn(2'b01, 3, 16'($urandom), 0);
    txn(2'b10, 2, 16'h0300, 0);

    // contention: both held valid, order must alternate 0,1,0,1
    for (int i = 0; i < 4; i++)
      txn(2'b11, int'($urandom_range(1, 8)), 16'($urandom), 0);

    for (int i = 0; i < 6; i++)
      txn(2'($urandom_range(1, 3)), int'($urandom_range(1, 12)), 16'($urandom),
          int'($urandom_range(0, 15)));

`ifdef SDIO_ARB_TIMEOUT_EN
    txn(2'b01, 0, 16'($urandom), 100);
    txn(2'b01, 150, 16'($urandom), 0);
    txn(2'b10, 50, 16'($urandom), 50);
`else
    txn(2'b01, 120, 16'($urandom), 100);
    txn(2'b10, 7, 16'($urandom), 3);
`endif

    // reset in the middle of a transfer
    w_pre         = 1 - last_m;
    vif.req_valid = 2'b11;
    vif.req_desc  = {d[1], d[0]};
    tmo_cycles    = '0;
    eot           = 1'b0;
    #1;
    chk("prerst_ready", 64'(vif.req_ready), 64'(idx2oh(1'(w_pre))));
    repeat (4) @(negedge clk);
    #1;
    chk("prerst_busy", 64'(busy), 64'(1));
    rstn = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (2) @(negedge clk);
    #1;
    chk("midrst_hold_done", 64'(vif.done), 64'(0));
    chk("midrst_hold_ready", 64'(vif.req_ready), 64'(0));
    rstn   = 1'b1;
    last_m = 1;
    st_m   = '0;
    tmo_m  = 1'b0;
    txn(2'b11, 4, 16'($urandom), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdio_req_arb.md
SDIO_REQ_ARB -- requirements
Module: sdio_req_arb

Interface
REQ-001 Parameter TMO_W, default 24, width of the timeout counter and of tmo_cycles_i.
REQ-002 clk_i  input  1  system clock; every output is launched on the rising edge.
REQ-003 rstn_i  input  1  asynchronous active-low reset.
REQ-004 req_valid_i  input  2  per-requester descriptor valid.
REQ-005 req_ready_o  output  2  per-requester descriptor accepted; one-hot or zero.
REQ-006 req_desc_i  input  2 x sdio_req_t  per-requester descriptor: op[5:0], arg[31:0], rsp_type[2:0], data_en, rwn, quad, block_size[9:0], block_num[7:0].
REQ-007 done_o  output  2  per-requester completion pulse, one-hot or zero.
REQ-008 done_status_o  output  16  captured txrx status for the completing request.
REQ-009 done_tmo_o  output  1  completing request ended by timeout.
REQ-010 cmd_start_o  output  1  start pulse to the txrx core.
REQ-011 cmd_op_o / cmd_arg_o / cmd_rsp_type_o  output  6/32/3  latched command fields.
REQ-012 data_en_o / data_rwn_o / data_quad_o / data_block_size_o / data_block_num_o  output  1/1/1/10/8  latched data fields.
REQ-013 clr_stat_o  output  1  status clear pulse to the txrx core.
REQ-014 eot_i  input  1  end-of-transfer from the txrx core.
REQ-015 status_i  input  16  txrx status word.
REQ-016 tmo_cycles_i  input  TMO_W  timeout limit in clk_i cycles; 0 disables the timeout.
REQ-017 busy_o  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, LAUNCH, BUSY, DONE.
REQ-019 IDLE: when any req_valid_i is high, grant one requester, pulse its req_ready_o, latch its descriptor, record the grant index, go to LAUNCH.
REQ-020 Arbitration is round-robin: when both are valid, grant the requester that was not granted last; the last-granted pointer resets to 1, so requester 0 wins first.
REQ-021 req_ready_o is never high outside IDLE; valid held during BUSY is not accepted and is not dropped.
REQ-022 LAUNCH: cmd_start_o high for exactly one cycle, then go to BUSY; request accepted in cycle N gives cmd_start_o in cycle N+1.
REQ-023 Command/data outputs hold the latched descriptor from LAUNCH until the next grant and do not change during BUSY.
REQ-024 BUSY: on eot_i high, capture status_i and go to DONE; eot_i in any other state is ignored.
REQ-025 DONE: done_o[grant] and clr_stat_o high for one cycle with done_status_o valid, then go to IDLE; next grant is possible in the cycle after DONE.
REQ-026 done_status_o and done_tmo_o hold their values until the next DONE.
REQ-027 eot_i in the same cycle as the timeout expiry: eot wins and done_tmo_o=0.

Reset
REQ-028 With rstn_i low: state IDLE, all outputs 0, latched descriptor 0, pointer 1, counter 0.
REQ-029 Reset mid-transfer aborts silently: no done_o pulse is produced and the txrx core is not notified.

Configuration
REQ-030 Macro SDIO_ARB_TIMEOUT_EN defined: a TMO_W-bit counter clears on entry to BUSY and increments each BUSY cycle; when it reaches tmo_cycles_i (nonzero), capture status_i, set done_tmo_o=1 and go to DONE.
REQ-031 SDIO_ARB_TIMEOUT_EN undefined: no counter is built, tmo_cycles_i is ignored, done_tmo_o is tied 0, and BUSY exits only on eot_i.

Structure
REQ-032 Package sdio_pkg holds sdio_req_t, the FSM state enum and the status-bit position constants.
REQ-033 One sub-module, sdio_rr_arb2: a 2-way round-robin grant with pointer update on accept; the timeout counter stays inline.

Verification
REQ-034 Single request: req 0 valid with op=17, arg=0x200, block_num=0 -> ready0 at N, cmd_start_o at N+1 with cmd_op_o=17; eot_i at M -> done_o=01 at M+1, clr_stat_o=1.
REQ-035 Contention: both valid continuously for four transactions -> grant order 0,1,0,1; no ready while busy_o=1.
REQ-036 Status capture: status_i=0x0300 at eot -> done_status_o=0x0300 and held until the next DONE.
REQ-037 Timeout (macro on): tmo_cycles_i=100 and no eot -> done_o pulse after 100 BUSY cycles with done_tmo_o=1; repeat with tmo_cycles_i=0 -> no done until eot.
REQ-038 Tie: eot_i on the expiry cycle -> done_tmo_o=0.
REQ-039 Reset mid-BUSY: assert rstn_i -> all outputs 0, no done_o; after release, pending req 0 is granted first.
